// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state encoding, sprite/screen geometry and the
// horizontal step-with-clamp helper used by the controller.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BACK       = 3'd1,
        ST_FWD        = 3'd2,
        ST_ATK_START  = 3'd3,
        ST_ATK_ACTIVE = 3'd4,
        ST_ATK_RECOV  = 3'd5,
        ST_HITSTUN    = 3'd6
    } fstate_t;

    localparam int SPRITE_WIDTH  = 64;
    localparam int SPRITE_HEIGHT = 128;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int X_LEFT        = 0;
    localparam int X_RIGHT       = SCREEN_WIDTH - SPRITE_WIDTH;

    // One walking step. Done in 11 bits so neither 0-speed nor 1023+speed wraps.
    function automatic logic [9:0] step_x(input logic [9:0] x, input logic fwd,
                                          input int speed, input int xmin, input int xmax);
        logic [10:0] xe, sp, lo, hi, nx;
        xe = {1'b0, x};
        sp = 11'(speed);
        lo = 11'(xmin);
        hi = 11'(xmax);
        if (fwd) begin
            nx = xe + sp;
            if (nx > hi) nx = hi;
        end else begin
            if (xe < lo + sp) nx = lo;
            else              nx = xe - sp;
        end
        return 10'(nx);
    endfunction

    // Attack phases and hitstun lock out the buttons.
    function automatic logic is_busy(input fstate_t s);
        return (s == ST_ATK_START) || (s == ST_ATK_ACTIVE) ||
               (s == ST_ATK_RECOV) || (s == ST_HITSTUN);
    endfunction

endpackage

// File: rtl/fighter_ctrl_if.sv
// Frame strobe, buttons and hit input into the fighter; state and sprite
// position back out to the box generator.
interface fighter_ctrl_if;
    import fighter_pkg::*;

    logic       frame_tick;
    logic       btn_fwd;
    logic       btn_back;
    logic       btn_attack;
    logic       hit_taken;
    fstate_t    state;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       busy;

    modport master (
        output frame_tick, btn_fwd, btn_back, btn_attack, hit_taken,
        input  state, sprite_x, sprite_y, busy
    );

    modport slave (
        input  frame_tick, btn_fwd, btn_back, btn_attack, hit_taken,
        output state, sprite_x, sprite_y, busy
    );

endinterface

// File: rtl/fighter_ctrl_frame_timer.sv
// Phase timer: 4-bit loadable down-counter; load beats dec, dec stops at zero.
module frame_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)                     cnt_d = load_val;
        else if (dec && cnt_q != '0)  cnt_d = cnt_q - W'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fighter_ctrl.sv
// Fighter movement/attack/hitstun controller. Everything except the sticky
// hit flag advances only on frame ticks.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int X_INIT      = 100,
    parameter int X_MIN       = X_LEFT,
    parameter int X_MAX       = X_RIGHT,
    parameter int Y_GROUND    = 300,
    parameter int SPEED       = 4,
    parameter int STARTUP_FR  = 4,
    parameter int ACTIVE_FR   = 3,
    parameter int RECOVERY_FR = 8,
    parameter int HITSTUN_FR  = 12
) (
    input  logic           clk,
    input  logic           rst,
    fighter_ctrl_if.slave  bus
);

    if (STARTUP_FR < 1 || STARTUP_FR > 16 || ACTIVE_FR  < 1 || ACTIVE_FR  > 16 ||
        RECOVERY_FR < 1 || RECOVERY_FR > 16 || HITSTUN_FR < 1 || HITSTUN_FR > 16) begin : g_fr_check
        $error("fighter_ctrl: every *_FR parameter must be in 1..16");
    end

    fstate_t    state_q, state_d;
    logic [9:0] x_q, x_d;
    logic       armed_q, armed_d;
    logic       hit_pend_q, hit_pend_d;
    logic       busy_q;
    logic       tmr_load, tmr_dec, tmr_zero;
    logic [3:0] tmr_val;
    logic       hit_now;

    frame_timer #(.W(4)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // A hit landing on the tick cycle itself counts for that tick.
    assign hit_now = hit_pend_q | bus.hit_taken;

    // Next-state, position, arming and timer control for the coming tick.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        armed_d    = armed_q;
        hit_pend_d = hit_pend_q | bus.hit_taken;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        if (bus.frame_tick) begin
            hit_pend_d = 1'b0;
            // Any tick with the button up re-arms, even while busy.
            if (!bus.btn_attack) armed_d = 1'b1;
            if (hit_now) begin
                state_d  = ST_HITSTUN;
                tmr_load = 1'b1;
                tmr_val  = 4'(HITSTUN_FR - 1);
            end else begin
                case (state_q)
                    ST_IDLE, ST_BACK, ST_FWD: begin
                        if (bus.btn_attack && armed_q) begin
                            state_d  = ST_ATK_START;
                            armed_d  = 1'b0;
                            tmr_load = 1'b1;
                            tmr_val  = 4'(STARTUP_FR - 1);
                        end else if (bus.btn_fwd ^ bus.btn_back) begin
                            state_d = bus.btn_fwd ? ST_FWD : ST_BACK;
                            x_d     = step_x(x_q, bus.btn_fwd, SPEED, X_MIN, X_MAX);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        if (!tmr_zero) begin
                            tmr_dec = 1'b1;
                        end else begin
                            case (state_q)
                                ST_ATK_START: begin
                                    state_d  = ST_ATK_ACTIVE;
                                    tmr_load = 1'b1;
                                    tmr_val  = 4'(ACTIVE_FR - 1);
                                end
                                ST_ATK_ACTIVE: begin
                                    state_d  = ST_ATK_RECOV;
                                    tmr_load = 1'b1;
                                    tmr_val  = 4'(RECOVERY_FR - 1);
                                end
                                default: state_d = ST_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // State registers; reset aborts any attack/hitstun and drops a pending hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= 10'(X_INIT);
            armed_q    <= 1'b1;
            hit_pend_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            armed_q    <= armed_d;
            hit_pend_q <= hit_pend_d;
            busy_q     <= is_busy(state_d);
        end
    end

    assign bus.state    = state_q;
    assign bus.sprite_x = x_q;
    assign bus.sprite_y = 10'(Y_GROUND);
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Bench for fighter_ctrl: directed scenarios plus random traffic, checked
// every cycle against a phase-elapsed reference model.
module tb_fighter_ctrl;
    import fighter_pkg::*;

    localparam int XI = 100, XMN = 0, XMX = 576, YG = 300, SPD = 4;
    localparam int SFR = 4, AFR = 3, RFR = 8, HFR = 12;

    logic clk = 1'b0;
    logic rst, rst2;
    int   total = 0, bad = 0;

    fighter_ctrl_if bus();
    fighter_ctrl_if bus2();

    fighter_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));
    fighter_ctrl #(.X_INIT(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    always #5 clk = ~clk;

    // Reference model: mode 0=free, 1=attacking, 2=hitstun; el = ticks since entry.
    int m_mode, m_fs, m_el, m_x;
    bit m_armed, m_pend;

    function automatic int exp_state();
        if (m_mode == 1) return (m_el < SFR) ? 3 : (m_el < SFR + AFR) ? 4 : 5;
        if (m_mode == 2) return 6;
        return m_fs;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fs = 0; m_el = 0; m_x = XI; m_armed = 1; m_pend = 0;
    endtask

    task automatic model_tick(input bit f, input bit b, input bit a, input bit h);
        bit hn;
        hn = m_pend || h;
        m_pend = 0;
        if (!a) m_armed = 1;
        if (hn) begin
            m_mode = 2; m_el = 0;
        end else if (m_mode == 0) begin
            if (a && m_armed) begin
                m_mode = 1; m_el = 0; m_armed = 0;
            end else if (f != b) begin
                m_fs = f ? 2 : 1;
                m_x  = f ? ((m_x + SPD > XMX) ? XMX : m_x + SPD)
                         : ((m_x - SPD < XMN) ? XMN : m_x - SPD);
            end else begin
                m_fs = 0;
            end
        end else begin
            m_el++;
            if ((m_mode == 1 && m_el == SFR + AFR + RFR) || (m_mode == 2 && m_el == HFR)) begin
                m_mode = 0; m_fs = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock on the main DUT: apply inputs, step model, compare all outputs.
    task automatic cyc(input bit t, input bit f, input bit b, input bit a, input bit h, input bit r);
        bus.frame_tick = t; bus.btn_fwd = f; bus.btn_back = b;
        bus.btn_attack = a; bus.hit_taken = h; rst = r;
        @(posedge clk);
        if (r)      model_reset();
        else if (t) model_tick(f, b, a, h);
        else if (h) m_pend = 1;
        #1;
        chk("state", int'(bus.state), exp_state());
        chk("sprite_x", int'(bus.sprite_x), m_x);
        chk("sprite_y", int'(bus.sprite_y), YG);
        chk("busy", int'(bus.busy), (exp_state() >= 3) ? 1 : 0);
    endtask

    task automatic cyc2(input bit t, input bit f, input bit b, input bit r);
        bus2.frame_tick = t; bus2.btn_fwd = f; bus2.btn_back = b;
        bus2.btn_attack = 1'b0; bus2.hit_taken = 1'b0; rst2 = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n4, n6, starts, prev;
        bit ra;
        model_reset();
        rst2 = 1'b1;
        bus2.frame_tick = 0; bus2.btn_fwd = 0; bus2.btn_back = 0;
        bus2.btn_attack = 0; bus2.hit_taken = 0;

        // Reset, then a bare tick.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_idle", int'(bus.state), 0);
        chk("rst_x", int'(bus.sprite_x), 100);
        chk("rst_busy", int'(bus.busy), 0);

        // Walk forward three ticks, with idle cycles between (no movement there).
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0, 0);
        end
        chk("walk3_x", int'(bus.sprite_x), 112);
        cyc(1, 1, 1, 0, 0, 0);
        chk("both_idle", int'(bus.state), 0);

        // Attack pulsed across one tick with forward held throughout.
        cyc(1, 1, 0, 1, 0, 0);
        chk("atk_start", int'(bus.state), 3);
        n4 = 0;
        for (int i = 0; i < SFR + AFR + RFR - 1; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            if (bus.state == ST_ATK_ACTIVE) n4++;
        end
        chk("active_len", n4, AFR);
        chk("atk_last_recov", int'(bus.state), 5);
        cyc(1, 1, 0, 0, 0, 0);
        chk("atk_end_idle", int'(bus.state), 0);
        chk("atk_x_frozen", int'(bus.sprite_x), 112);

        // Hold attack for 30 ticks: exactly one sequence.
        starts = 0; prev = int'(bus.state);
        for (int i = 0; i < 30; i++) begin
            cyc(1, 0, 0, 1, 0, 0);
            if (bus.state == ST_ATK_START && prev != 3) starts++;
            prev = int'(bus.state);
        end
        chk("hold_one_attack", starts, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        chk("rearm_attack", int'(bus.state), 3);

        // Hit between ticks during the active phase, then re-hit on the 6th hitstun tick.
        for (int i = 0; i < SFR; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("in_active", int'(bus.state), 4);
        cyc(0, 0, 0, 0, 1, 0);
        chk("hit_waits_tick", int'(bus.state), 4);
        cyc(1, 0, 0, 0, 0, 0);
        n6 = (bus.state == ST_HITSTUN) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 1, 0, 0);
            if (bus.state == ST_HITSTUN) n6++;
        end
        cyc(1, 0, 0, 0, 1, 0);
        if (bus.state == ST_HITSTUN) n6++;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            if (bus.state == ST_HITSTUN) n6++;
        end
        chk("hitstun_len", n6, 1 + 5 + HFR);
        chk("hitstun_x", int'(bus.sprite_x), 112);

        // Reset during the active phase with a tick and a pending hit.
        cyc(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < SFR; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("rst_abort_state", int'(bus.state), 0);
        chk("rst_abort_x", int'(bus.sprite_x), XI);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pend_dropped", int'(bus.state), 0);

        // Random traffic.
        ra = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            cyc(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                ra, ($urandom_range(0, 29) == 0), ($urandom_range(0, 299) == 0));
        end

        // Edge clamps on a second instance starting at x=2.
        cyc2(0, 0, 0, 1);
        cyc2(1, 0, 1, 0);
        chk("clamp_min", int'(bus2.sprite_x), 0);
        cyc2(0, 0, 0, 1);
        for (int i = 0; i < 143; i++) cyc2(1, 1, 0, 0);
        chk("walk_574", int'(bus2.sprite_x), 2 + 4 * 143);
        cyc2(1, 1, 0, 0);
        chk("clamp_max", int'(bus2.sprite_x), XMX);
        cyc2(1, 1, 0, 0);
        chk("clamp_hold", int'(bus2.sprite_x), XMX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
